nano_io_ctrl: RTL

- Sequencer for the Nano processor's INPUT/OUTPUT instructions; sits between the control FSM and the external I/O ports.
- Converts one-cycle read/write requests from the control FSM into valid/ready handshakes with the input and output devices.
- Stalls the control FSM until each transfer completes. A programmable timeout stops the processor hanging on a dead device.

---
 rtl/nano_pkg.sv | 17 +
 rtl/nano_io_timer.sv | 31 +++
 rtl/nano_io_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/nano_pkg.sv
// Shared definitions for the Nano processor I/O path: state encoding, data width
// and the INPUT/OUTPUT opcodes that the control FSM decodes.
package nano_pkg;

  localparam int NANO_DATA_W = 8;

  localparam logic [3:0] OP_INPUT  = 4'hE;
  localparam logic [3:0] OP_OUTPUT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_IN  = 2'd1,
    S_WAIT_OUT = 2'd2,
    S_DONE     = 2'd3
  } io_state_t;

endpackage

// File: rtl/nano_io_timer.sv
// Saturating wait-state counter. expire flags the last permitted wait cycle;
// TIMEOUT of zero means the counter never expires.
module nano_io_timer #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LIMIT = (TIMEOUT == 0) ? {TO_W{1'b1}} : TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  // NOTE: non-blocking assignments for every flop so all state updates on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/nano_io_ctrl.sv
// I/O sequencer for the Nano processor: turns INPUT/OUTPUT request pulses into
// valid/ready handshakes, stalls the control FSM and abandons dead transfers.
module nano_io_ctrl
  import nano_pkg::*;
#(
  parameter int DATA_W  = NANO_DATA_W,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall,
  output logic              done,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              timeout,
  output logic              err,
  input  logic              flag_clr
);

  io_state_t         state, state_n;
  logic [DATA_W-1:0] rd_data_n, out_data_n;
  logic              stall_n, done_n, in_ready_n, out_valid_n, timeout_n, err_n;
  logic              tmr_clr, tmr_en, tmr_expire;

  nano_io_timer #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rd_data   <= '0;
      out_data  <= '0;
      stall     <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      timeout   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      rd_data   <= rd_data_n;
      out_data  <= out_data_n;
      stall     <= stall_n;
      done      <= done_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      timeout   <= timeout_n;
      err       <= err_n;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_n     = state;
    rd_data_n   = rd_data;
    out_data_n  = out_data;
    stall_n     = stall;
    done_n      = 1'b0;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    timeout_n   = timeout & ~flag_clr;
    err_n       = err & ~flag_clr;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (rd_req) begin
          // A simultaneous write is dropped; the read takes priority.
          state_n    = S_WAIT_IN;
          stall_n    = 1'b1;
          in_ready_n = 1'b1;
          tmr_clr    = 1'b1;
          if (wr_req) err_n = 1'b1;
        end else if (wr_req) begin
          state_n     = S_WAIT_OUT;
          out_data_n  = wr_data;
          stall_n     = 1'b1;
          out_valid_n = 1'b1;
          tmr_clr     = 1'b1;
        end
      end

      S_WAIT_IN: begin
        if (rd_req || wr_req) err_n = 1'b1;
        if (in_valid && in_ready) begin
          state_n    = S_DONE;
          rd_data_n  = in_data;
          in_ready_n = 1'b0;
          stall_n    = 1'b0;
          done_n     = 1'b1;
        end else if (tmr_expire) begin
          state_n    = S_DONE;
          rd_data_n  = '0;
          timeout_n  = 1'b1;
          in_ready_n = 1'b0;
          stall_n    = 1'b0;
          done_n     = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end

      S_WAIT_OUT: begin
        if (rd_req || wr_req) err_n = 1'b1;
        if (out_ready) begin
          state_n     = S_DONE;
          out_valid_n = 1'b0;
          stall_n     = 1'b0;
          done_n      = 1'b1;
        end else if (tmr_expire) begin
          state_n     = S_DONE;
          timeout_n   = 1'b1;
          out_valid_n = 1'b0;
          stall_n     = 1'b0;
          done_n      = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end

      S_DONE: begin
        if (rd_req || wr_req) err_n = 1'b1;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
